// File: rtl/exotiny_spi_target.sv
// exotiny_spi_target: mode-0 SPI target for the ExoTiny iCE40 validation board.
// The target replies with a delayed echo or a constant pattern, and it reports
// each received word plus a running word count.
// Optional feature: define EXOTINY_SPI_TGT_CHECK_EN to add an incrementing-pattern
// checker that drives err_o. When the macro is not defined, err_o is tied to 0.
module exotiny_spi_target #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cs_ni,
    input  logic             sck_i,
    input  logic             sdi_i,
    output logic             sdo_o,
    input  logic [1:0]       mode_i,
    output logic [WIDTH-1:0] rx_data_o,
    output logic             rx_valid_o,
    output logic [7:0]       word_cnt_o,
    output logic             err_o
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, SHIFT} state_e;

    state_e           state_q;
    logic             sck_q, cs_q;
    logic             reload_q;
    logic [CW-1:0]    bit_cnt_q;
    logic [WIDTH-1:0] tx_sr_q, rx_sr_q, echo_q, rx_data_q;
    logic [7:0]       word_cnt_q;
    logic             rx_valid_q;

    logic             rise, fall, start, last_bit, word_done;
    logic [WIDTH-1:0] rx_word_d, resp_d;

    assign rise      = sck_i & ~sck_q;
    assign fall      = ~sck_i & sck_q;
    assign start     = ~cs_ni & cs_q;
    assign last_bit  = (bit_cnt_q == CW'(WIDTH - 1));
    assign rx_word_d = {rx_sr_q[WIDTH-2:0], sdi_i};
    // A rise in the same cycle as a deassert does not complete a word.
    assign word_done = (state_q == SHIFT) & ~cs_ni & rise & last_bit;

    // The response word comes from the mode value seen on the load cycle.
    always_comb begin
        resp_d = '1;
        if (mode_i == 2'b00)      resp_d = echo_q;
        else if (mode_i == 2'b01) resp_d = '0;
    end

    // Registered copies of SCK and CS, used for edge and frame-start detection.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sck_q <= 1'b0;
            cs_q  <= 1'b0;
        end else begin
            sck_q <= sck_i;
            cs_q  <= cs_ni;
        end
    end

    // Frame FSM: capture on rise, shift out or reload on fall.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            tx_sr_q    <= '1;
            rx_sr_q    <= '0;
            echo_q     <= '0;
            rx_data_q  <= '0;
            word_cnt_q <= '0;
            rx_valid_q <= 1'b0;
            reload_q   <= 1'b0;
            bit_cnt_q  <= '0;
        end else begin
            rx_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= SHIFT;
                        tx_sr_q   <= resp_d;
                        bit_cnt_q <= '0;
                        reload_q  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (cs_ni) begin
                        // Any partial word is dropped.
                        state_q   <= IDLE;
                        bit_cnt_q <= '0;
                        reload_q  <= 1'b0;
                    end else if (rise) begin
                        rx_sr_q <= rx_word_d;
                        if (last_bit) begin
                            rx_data_q  <= rx_word_d;
                            echo_q     <= rx_word_d;
                            word_cnt_q <= word_cnt_q + 8'd1;
                            rx_valid_q <= 1'b1;
                            bit_cnt_q  <= '0;
                            reload_q   <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CW'(1);
                        end
                    end else if (fall) begin
                        if (reload_q) begin
                            tx_sr_q  <= resp_d;
                            reload_q <= 1'b0;
                        end else begin
                            tx_sr_q <= {tx_sr_q[WIDTH-2:0], 1'b0};
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef EXOTINY_SPI_TGT_CHECK_EN
    logic [WIDTH-1:0] exp_q;
    logic             err_q;

    // Pattern checker: it flags a word that is not the previous word + 1.
    // After each word it resyncs to the received value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            exp_q <= '0;
            err_q <= 1'b0;
        end else if (word_done) begin
            if (rx_word_d != exp_q) err_q <= 1'b1;
            exp_q <= rx_word_d + WIDTH'(1);
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign sdo_o      = (state_q == SHIFT) ? tx_sr_q[WIDTH-1] : 1'b1;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign word_cnt_o = word_cnt_q;

endmodule

// File: tb/tb_exotiny_spi_target.sv
// Randomized bench for exotiny_spi_target. The bench acts as the SPI master.
// A word-level reference model predicts the bytes the core should receive and
// the receive-side status outputs.
module tb_exotiny_spi_target;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_i, cs_ni, sck_i, sdi_i, sdo_o, rx_valid_o, err_o;
    logic [1:0]   mode_i;
    logic [W-1:0] rx_data_o;
    logic [7:0]   word_cnt_o;

    exotiny_spi_target #(.WIDTH(W)) dut (
        .clk_i(clk), .rst_i(rst_i), .cs_ni(cs_ni), .sck_i(sck_i), .sdi_i(sdi_i),
        .sdo_o(sdo_o), .mode_i(mode_i), .rx_data_o(rx_data_o),
        .rx_valid_o(rx_valid_o), .word_cnt_o(word_cnt_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state, tracked at the word level.
    logic [7:0] m_last, m_cnt, m_exp;
    logic       m_err;

    logic [7:0] fq_d[$];
    logic [1:0] fq_m[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_last = '0; m_cnt = '0; m_exp = '0; m_err = 1'b0;
    endtask

    task automatic model_word(input logic [7:0] d);
        m_last = d;
        m_cnt  = m_cnt + 8'd1;
`ifdef EXOTINY_SPI_TGT_CHECK_EN
        if (d != m_exp) m_err = 1'b1;
        m_exp = d + 8'd1;
`endif
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "_data"}, rx_data_o, m_last);
        chk({tag, "_cnt"}, word_cnt_o, m_cnt);
        chk({tag, "_err"}, err_o, m_err);
    endtask

    // Sends one word, MSB first. The next word's mode is applied just before
    // the final fall, because the response is reloaded on that fall.
    task automatic send_word(input logic [7:0] d, input logic [1:0] cur_mode,
                             input logic [1:0] nxt_mode);
        logic [7:0] resp, got;
        resp = (cur_mode == 2'b00) ? m_last : (cur_mode == 2'b01) ? 8'h00 : 8'hFF;
        got  = '0;
        for (int i = W - 1; i >= 0; i--) begin
            sdi_i = d[i];
            cyc(2);
            got[i] = sdo_o;
            sck_i = 1'b1;
            cyc(1);
            chk("valid", rx_valid_o, (i == 0));
            if (i == 0) begin
                model_word(d);
                chk_status("word");
            end
            cyc(1);
            if (i == 4) mode_i = 2'($urandom);
            if (i == 0) mode_i = nxt_mode;
            sck_i = 1'b0;
        end
        chk("sdo_word", got, resp);
    endtask

    task automatic run_frame();
        cs_ni = 1'b1;
        cyc(2);
        mode_i = fq_m[0];
        cs_ni  = 1'b0;
        cyc(2);
        for (int k = 0; k < fq_d.size(); k++)
            send_word(fq_d[k], fq_m[k], (k + 1 < fq_m.size()) ? fq_m[k+1] : 2'($urandom));
        cyc(2);
        cs_ni = 1'b1;
        cyc(1);
        chk("idle_sdo", sdo_o, 1'b1);
        cyc(1);
        fq_d.delete();
        fq_m.delete();
    endtask

    // Sends nbits of a word and then aborts the frame. With simul set, the
    // deassert happens together with the next rise.
    task automatic partial(input int nbits, input bit simul);
        cs_ni = 1'b1;
        cyc(2);
        cs_ni = 1'b0;
        cyc(2);
        for (int i = 0; i < nbits; i++) begin
            sdi_i = 1'($urandom);
            cyc(2);
            sck_i = 1'b1;
            cyc(1);
            chk("part_valid", rx_valid_o, 1'b0);
            cyc(1);
            sck_i = 1'b0;
        end
        cyc(2);
        sdi_i = 1'($urandom);
        if (simul) begin
            sck_i = 1'b1;
            cs_ni = 1'b1;
            cyc(1);
            chk("simul_valid", rx_valid_o, 1'b0);
            cyc(1);
            sck_i = 1'b0;
            cyc(1);
        end else begin
            cs_ni = 1'b1;
            cyc(2);
        end
        chk_status("part");
    endtask

    initial begin
        rst_i = 1'b1; cs_ni = 1'b0; sck_i = 1'b0; sdi_i = 1'b0; mode_i = 2'b00;
        model_reset();
        cyc(3);
        rst_i = 1'b0;
        cyc(1);
        chk("rst_sdo", sdo_o, 1'b1);
        chk("rst_valid", rx_valid_o, 1'b0);
        chk_status("rst");

        // Holding CS low through reset release must not start a frame.
        for (int i = 0; i < W; i++) begin
            sdi_i = 1'b1;
            cyc(2);
            chk("nofrm_sdo", sdo_o, 1'b1);
            sck_i = 1'b1;
            cyc(1);
            chk("nofrm_valid", rx_valid_o, 1'b0);
            cyc(1);
            sck_i = 1'b0;
        end
        cyc(2);
        chk_status("nofrm");

        // An incrementing stream in echo mode.
        for (int i = 0; i < 6; i++) begin
            fq_d.push_back(8'(i));
            fq_m.push_back(2'b00);
        end
        run_frame();

        fq_d = '{8'hA5, 8'h3C};
        fq_m = '{2'b00, 2'b00};
        run_frame();

        fq_d = '{8'hFF, 8'hFF};
        fq_m = '{2'b01, 2'b10};
        run_frame();

        partial(5, 1'b0);
        fq_d = '{8'h81};
        fq_m = '{2'b00};
        run_frame();

        partial(7, 1'b1);
        fq_d = '{8'h42};
        fq_m = '{2'b00};
        run_frame();

        for (int f = 0; f < 5; f++) begin
            int n;
            n = $urandom_range(1, 5);
            for (int k = 0; k < n; k++) begin
                fq_d.push_back(8'($urandom));
                fq_m.push_back(2'($urandom));
            end
            run_frame();
        end

        // This frame carries the word count through 255 -> 0.
        for (int k = 0; k < 256; k++) begin
            fq_d.push_back(8'($urandom));
            fq_m.push_back(2'($urandom));
        end
        run_frame();

        // Assert reset in the middle of a word.
        cs_ni = 1'b1;
        cyc(2);
        cs_ni = 1'b0;
        cyc(2);
        for (int i = 0; i < 3; i++) begin
            sdi_i = 1'($urandom);
            cyc(2);
            sck_i = 1'b1;
            cyc(2);
            sck_i = 1'b0;
        end
        rst_i = 1'b1;
        cs_ni = 1'b1;
        cyc(1);
        model_reset();
        chk("mrst_sdo", sdo_o, 1'b1);
        chk("mrst_valid", rx_valid_o, 1'b0);
        chk_status("mrst");
        rst_i = 1'b0;
        cyc(1);

        fq_d = '{8'h00, 8'h02};
        fq_m = '{2'b00, 2'b00};
        run_frame();
        fq_d = '{8'h03};
        fq_m = '{2'b00};
        run_frame();
        chk_status("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule
